// File: rtl/tick_scheduler.sv
// Programmable multi-channel clock-enable generator: each channel emits a one-cycle
// tick every (div+1) cycles plus a slow_clk level that toggles on every tick.
module tick_scheduler #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 262143,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  input  logic [NUM_CH-1:0] run_en,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] slow_clk
);

  localparam int NUM_W = CH_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic cfg_valid_s;
  logic cfg_err_r;

  assign cfg_valid_s = ({1'b0, cfg_ch} < NUM_W'(NUM_CH));
  assign cfg_err     = cfg_err_r;

  // Flag writes aimed at a channel that does not exist
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we & ~cfg_valid_s;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] act_r, act_s;
    logic [CNT_W-1:0] shadow_r;
    logic             tick_r, tick_s;
    logic             slow_r, slow_s;
    logic             wr_s;

    assign wr_s        = cfg_we & cfg_valid_s & (cfg_ch == CH_W'(i));
    assign tick[i]     = tick_r;
    assign slow_clk[i] = slow_r;

    // State register
    always_ff @(posedge clk_100MHz) begin
      if (rst) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_s;
      end
    end

    // Next-state decode: the run level alone moves a channel between IDLE and RUN
    always_comb begin
      state_s = state_r;
      case (state_r)
        IDLE: begin
          if (run_en[i]) state_s = RUN;
          else           state_s = IDLE;
        end
        RUN: begin
          if (run_en[i]) state_s = RUN;
          else           state_s = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end

    // Datapath next values; priority is run_en low > sync_req > terminal count > increment
    always_comb begin
      cnt_s  = cnt_r;
      act_s  = act_r;
      tick_s = 1'b0;
      slow_s = slow_r;
      case (state_r)
        IDLE: begin
          cnt_s  = '0;
          slow_s = 1'b0;
          if (run_en[i]) act_s = shadow_r;
          else           act_s = act_r;
        end
        RUN: begin
          if (!run_en[i]) begin
            cnt_s  = '0;
            slow_s = 1'b0;
          end else if (sync_req) begin
            cnt_s  = '0;
            slow_s = 1'b0;
            act_s  = shadow_r;
          end else if (cnt_r == act_r) begin
            // Divisor changes are adopted only here, so no period is ever cut short
            cnt_s  = '0;
            tick_s = 1'b1;
            slow_s = ~slow_r;
            act_s  = shadow_r;
          end else begin
            cnt_s  = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_s  = '0;
          slow_s = 1'b0;
        end
      endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_100MHz) begin
      if (rst) begin
        cnt_r    <= '0;
        act_r    <= CNT_W'(DEFAULT_DIV);
        shadow_r <= CNT_W'(DEFAULT_DIV);
        tick_r   <= 1'b0;
        slow_r   <= 1'b0;
      end else begin
        cnt_r  <= cnt_s;
        act_r  <= act_s;
        tick_r <= tick_s;
        slow_r <= slow_s;
        if (wr_s) shadow_r <= cfg_div;
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios then random traffic,
// compared every cycle against a deadline-based reference model.
module tb_tick_scheduler;

  localparam int N   = 3;
  localparam int W   = 24;
  localparam int DEF = 37;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_err;
  logic [N-1:0]  run_en;
  logic          sync_req;
  logic [N-1:0]  tick;
  logic [N-1:0]  slow_clk;

  int     checks   = 0;
  int     failures = 0;
  longint t        = 0;

  // Reference model: a channel ticks when the edge count reaches its deadline
  bit           m_run [N];
  longint       m_dl  [N];
  longint       m_sh  [N];
  logic [N-1:0] m_tick;
  logic [N-1:0] m_slow;
  logic         m_err;

  tick_scheduler #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(DEF)) dut (
    .clk_100MHz(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .run_en(run_en),
    .sync_req(sync_req),
    .tick(tick),
    .slow_clk(slow_clk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    t++;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_run[c] = 1'b0;
        m_sh[c]  = DEF;
        m_dl[c]  = 0;
      end
      m_tick = '0;
      m_slow = '0;
      m_err  = 1'b0;
    end else begin
      m_err = cfg_we && (cfg_ch >= N);
      for (int c = 0; c < N; c++) begin
        m_tick[c] = 1'b0;
        if (!run_en[c]) begin
          m_run[c]  = 1'b0;
          m_slow[c] = 1'b0;
        end else if (!m_run[c] || sync_req) begin
          m_run[c]  = 1'b1;
          m_slow[c] = 1'b0;
          m_dl[c]   = t + m_sh[c] + 1;
        end else if (t == m_dl[c]) begin
          m_tick[c] = 1'b1;
          m_slow[c] = ~m_slow[c];
          m_dl[c]   = t + m_sh[c] + 1;
        end
      end
      if (cfg_we && cfg_ch < N) m_sh[cfg_ch] = cfg_div;
    end
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("tick", tick, m_tick);
      chk("slow_clk", slow_clk, m_slow);
      chk("cfg_err", cfg_err, m_err);
      cfg_we   = 1'b0;
      sync_req = 1'b0;
    end
  endtask

  task automatic write_div(input logic [1:0] ch, input int div);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = W'(div);
    cycle(1);
  endtask

  initial begin
    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    run_en   = '0;
    sync_req = 1'b0;
    cycle(3);
    chk("rst_tick", tick, 0);
    chk("rst_slow", slow_clk, 0);
    chk("rst_err", cfg_err, 0);
    rst = 1'b0;

    // Default divisor on channel 0 only
    run_en = 3'b001;
    cycle(3 * (DEF + 1) + 5);
    run_en = 3'b000;
    cycle(2);

    // Divisor 3 written while idle, then enabled: ticks after edges 4, 8, 12
    write_div(2'd0, 3);
    run_en = 3'b001;
    cycle(1);
    for (int k = 1; k <= 12; k++) begin
      cycle(1);
      chk("t2_tick0", tick[0], (k % 4 == 0));
      chk("t2_slow0", slow_clk[0], (k / 4) % 2);
    end

    // Mid-period rewrite to 1: one more 4-cycle period, then period 2
    cycle(1);
    write_div(2'd0, 1);
    cycle(12);

    // Both channels running, then sync mid-period
    write_div(2'd0, 3);
    write_div(2'd1, 5);
    run_en = 3'b011;
    cycle(9);
    sync_req = 1'b1;
    cycle(1);
    chk("t4_sync_tick", tick[1:0], 0);
    chk("t4_sync_slow", slow_clk[1:0], 0);
    for (int k = 1; k <= 6; k++) begin
      cycle(1);
      chk("t4_tick0", tick[0], (k == 4));
      chk("t4_tick1", tick[1], (k == 6));
    end

    // Drop channel 1 while its slow_clk is high, then re-raise it
    for (int w = 0; w < 20 && slow_clk[1] !== 1'b1; w++) cycle(1);
    chk("t5_wait_slow1", slow_clk[1], 1);
    run_en[1] = 1'b0;
    cycle(1);
    chk("t5_drop_tick1", tick[1], 0);
    chk("t5_drop_slow1", slow_clk[1], 0);
    cycle(2);
    run_en[1] = 1'b1;
    cycle(1);
    for (int k = 1; k <= 6; k++) begin
      cycle(1);
      chk("t5_rerun_tick1", tick[1], (k == 6));
    end

    // Invalid channel write, then reset mid-run
    write_div(2'd3, 1);
    chk("t6_err_pulse", cfg_err, 1);
    cycle(1);
    chk("t6_err_clear", cfg_err, 0);
    cycle(4);
    rst = 1'b1;
    cycle(1);
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_slow", slow_clk, 0);
    rst = 1'b0;
    cycle(2 * (DEF + 1) + 4);

    // Random traffic
    for (int r = 0; r < 3000; r++) begin
      rst      = ($urandom % 400 == 0);
      cfg_we   = ($urandom % 8 == 0);
      cfg_ch   = 2'($urandom % 4);
      cfg_div  = W'($urandom % 6);
      sync_req = ($urandom % 40 == 0);
      for (int c = 0; c < N; c++) begin
        if ($urandom % 30 == 0) run_en[c] = ~run_en[c];
      end
      cycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
